keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
- Sequencing controller that sits directly downstream of the 20-key keypad encoder.
- Consumes the encoder's 5-bit key code and its "any key held" strobe, and turns each physical press into exactly one event using a release-plus-lockout debounce FSM.
- Assembles hex digits into a DIGITS-wide operand and supports clear, backspace, enter and recall.
- Hands committed operands to downstream logic with a single-cycle valid pulse.

Parameters:
- DIGITS, 8, number of hex digits held in the entry register (width 4*DIGITS).
- LOCKOUT_CYCLES, 10, cycles after key release during which new presses are ignored; 0 disables lockout.
- CNT_W, 8, width of the lockout/repeat counter; must hold LOCKOUT_CYCLES and REPEAT_DELAY.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- key_code  input  5  encoded key from keypad encoder; meaningful only while key_strobe=1.
- key_strobe  input  1  high while any key is held.
- entry  output  4*DIGITS  digits being typed, newest digit in bits [3:0].
- digit_cnt  output  $clog2(DIGITS+1)  number of digits currently in entry.
- value  output  4*DIGITS  last committed operand.
- value_valid  output  1  one-cycle pulse when value updates.
- err  output  1  one-cycle pulse on a rejected key action.
- busy  output  1  high when FSM is not IDLE.

Behaviour:
- Reset (rst=0, async): entry=0, digit_cnt=0, value=0, value_valid=0, err=0, FSM=IDLE, counter=0.
- FSM states: IDLE, HELD, LOCKOUT.
- IDLE:
  - key_strobe=1 at a rising edge is a press event; key_code is sampled at that same edge.
  - The action and any pulse take effect on that edge (zero added latency); next state is HELD.
- HELD:
  - Wait for key_strobe=0.
  - On release, go to LOCKOUT with counter=LOCKOUT_CYCLES-1, or straight to IDLE if LOCKOUT_CYCLES=0.
- LOCKOUT:
  - Counter decrements each cycle; key_strobe is ignored, so no events.
  - At counter=0: next state is IDLE if key_strobe=0; HELD if key_strobe=1 (that hold generates no event).
- Key actions on a press event:
  - Codes 0-15 (digits): if digit_cnt<DIGITS, entry <= {entry[4*DIGITS-5:0], code[3:0]} and digit_cnt++. If digit_cnt=DIGITS, entry is unchanged and err pulses.
  - Code 16 (clear): entry=0, digit_cnt=0. No err, even when already empty.
  - Code 17 (backspace): if digit_cnt>0, entry <= entry>>4 and digit_cnt--. Otherwise no change and err pulses.
  - Code 18 (enter): if digit_cnt>0, value<=entry, value_valid pulses, entry=0, digit_cnt=0. If digit_cnt=0, err pulses and value is unchanged.
  - Code 19 (recall): entry<=value, digit_cnt<=DIGITS.
  - Codes 20-31: ignored, no err.
- Outputs value_valid and err are registered and high for exactly one cycle per event. They are never both high in the same cycle.
- Only one event is possible per cycle. A strobe glitch shorter than one cycle that is sampled high counts as a press; debounce protection covers release bounce only.
- Reset mid-HELD or mid-LOCKOUT returns to IDLE. A key still held when rst deasserts is taken as a new press on the first active edge.
- busy = (state != IDLE).

Optional Feature:
- Macro: KEYPAD_AUTO_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 50) and REPEAT_RATE (default 10).
  - In HELD, if the held code is a digit or backspace, a repeat event is issued after REPEAT_DELAY cycles of continuous hold, then every REPEAT_RATE cycles. Each repeat applies the same action as the original press.
  - Counter restarts on entry to HELD.
  - Clear, enter, recall and ignored codes never repeat.
- Undefined: HELD only waits for release and generates no further events.

Test Plan (DIGITS=4, LOCKOUT_CYCLES=3):
- Press code 3 for 5 cycles, release 5 cycles, press 10, release, press 18 -> entry 0x0003 then 0x003A; on the enter edge value=0x003A, value_valid=1 for one cycle, entry=0, digit_cnt=0.
- Press digits 1,2,3,4,5 in sequence -> entry=0x1234, digit_cnt=4; err=1 for one cycle on the fifth press; entry unchanged.
- Press 1, 2, 17 -> entry=0x0001, digit_cnt=1; press 17, 17 -> entry=0, digit_cnt=0 after the first; err pulses on the second.
- Press 7, release 1 cycle, strobe high 2 cycles, low 1 cycle, then low 4 cycles -> exactly one digit (entry=0x0007); FSM ends in IDLE.
- Commit 0xBEEF, press 16, press 19 -> entry=0xBEEF, digit_cnt=4. Separately, press 18 with an empty entry -> err pulse, value stays 0xBEEF.
- Assert rst while in HELD with entry=0x0012 -> all outputs 0 immediately; key still held at rst deassert -> one press event recorded on the first edge.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Debounced keypad entry controller: one event per press, hex operand assembly, commit/recall.
// Optional auto-repeat for digit and backspace keys is enabled with KEYPAD_AUTO_REPEAT_EN.
module keypad_entry_ctrl #(
    parameter int DIGITS         = 8,
    parameter int LOCKOUT_CYCLES = 10,
    parameter int CNT_W          = 8
`ifdef KEYPAD_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   key_code,
    input  logic                         key_strobe,
    output logic [4*DIGITS-1:0]          entry,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic [4*DIGITS-1:0]          value,
    output logic                         value_valid,
    output logic                         err,
    output logic                         busy
);
    localparam int EW = 4 * DIGITS;
    localparam int DW = $clog2(DIGITS + 1);
    localparam logic [DW-1:0] FULL = DW'(DIGITS);

    typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             press;
    logic [4:0]       press_code;
    logic [EW-1:0]    entry_next;
    logic [EW-1:0]    value_next;
    logic [DW-1:0]    digit_cnt_next;
    logic             valid_next;
    logic             err_next;

`ifdef KEYPAD_AUTO_REPEAT_EN
    logic [4:0] held_code;
    logic       rep_ok;
    logic       rep_first;
    logic       rep_fire;

    // Repeat counter tracks continuous hold time since entering HELD or the last repeat.
    assign rep_fire   = (state == HELD) && key_strobe && rep_ok &&
                        (cnt == (rep_first ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1)));
    assign press      = ((state == IDLE) && key_strobe) || rep_fire;
    assign press_code = (state == IDLE) ? key_code : held_code;
`else
    assign press      = (state == IDLE) && key_strobe;
    assign press_code = key_code;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        entry_next     = entry;
        digit_cnt_next = digit_cnt;
        value_next     = value;
        valid_next     = 1'b0;
        err_next       = 1'b0;
        if (press) begin
            if (!press_code[4]) begin
                if (digit_cnt < FULL) begin
                    entry_next     = (entry << 4) | {{(EW-4){1'b0}}, press_code[3:0]};
                    digit_cnt_next = digit_cnt + 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end else begin
                case (press_code[3:0])
                    4'd0: begin
                        entry_next     = '0;
                        digit_cnt_next = '0;
                    end
                    4'd1: begin
                        if (digit_cnt != '0) begin
                            entry_next     = entry >> 4;
                            digit_cnt_next = digit_cnt - 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    4'd2: begin
                        if (digit_cnt != '0) begin
                            value_next     = entry;
                            valid_next     = 1'b1;
                            entry_next     = '0;
                            digit_cnt_next = '0;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    4'd3: begin
                        entry_next     = value;
                        digit_cnt_next = FULL;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            entry       <= '0;
            digit_cnt   <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            held_code   <= '0;
            rep_ok      <= 1'b0;
            rep_first   <= 1'b0;
`endif
        end else begin
            entry       <= entry_next;
            digit_cnt   <= digit_cnt_next;
            value       <= value_next;
            value_valid <= valid_next;
            err         <= err_next;
            case (state)
                IDLE: begin
                    if (key_strobe) begin
                        state <= HELD;
                        cnt   <= '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                        held_code <= key_code;
                        rep_ok    <= !key_code[4] || (key_code == 5'd17);
                        rep_first <= 1'b1;
`endif
                    end
                end
                HELD: begin
                    if (!key_strobe) begin
                        if (LOCKOUT_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= LOCKOUT;
                            cnt   <= CNT_W'(LOCKOUT_CYCLES - 1);
                        end
                    end
`ifdef KEYPAD_AUTO_REPEAT_EN
                    else if (rep_ok) begin
                        if (rep_fire) begin
                            cnt       <= '0;
                            rep_first <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                end
                LOCKOUT: begin
                    // A key still down when lockout expires is absorbed into HELD without an event.
                    if (cnt == '0) begin
                        state <= key_strobe ? HELD : IDLE;
`ifdef KEYPAD_AUTO_REPEAT_EN
                        rep_ok <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl with DIGITS=4, LOCKOUT_CYCLES=3.
module tb_keypad_entry_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  key_code;
    logic        key_strobe;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [15:0] value;
    logic        value_valid;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] value;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [15:0] m_entry = '0;
    logic [2:0]  m_cnt   = '0;
    logic [15:0] m_value = '0;

    keypad_entry_ctrl #(.DIGITS(4), .LOCKOUT_CYCLES(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_strobe(key_strobe),
        .entry(entry), .digit_cnt(digit_cnt), .value(value),
        .value_valid(value_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model of one press event; the expected post-edge outputs go to the scoreboard.
    task automatic model_press(input logic [4:0] c);
        exp_t e;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (c < 5'd16) begin
            if (m_cnt < 3'd4) begin
                m_entry = {m_entry[11:0], c[3:0]};
                m_cnt   = m_cnt + 3'd1;
            end else begin
                e.err = 1'b1;
            end
        end else if (c == 5'd16) begin
            m_entry = '0;
            m_cnt   = '0;
        end else if (c == 5'd17) begin
            if (m_cnt > 0) begin
                m_entry = m_entry >> 4;
                m_cnt   = m_cnt - 3'd1;
            end else begin
                e.err = 1'b1;
            end
        end else if (c == 5'd18) begin
            if (m_cnt > 0) begin
                m_value = m_entry;
                e.valid = 1'b1;
                m_entry = '0;
                m_cnt   = '0;
            end else begin
                e.err = 1'b1;
            end
        end else if (c == 5'd19) begin
            m_entry = m_value;
            m_cnt   = 3'd4;
        end
        e.entry = m_entry;
        e.cnt   = m_cnt;
        e.value = m_value;
        sb.push_back(e);
    endtask

    // Monitor: each edge either matches a queued event or must show no pulses.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            total++;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (entry !== mon_e.entry || digit_cnt !== mon_e.cnt || value !== mon_e.value ||
                    value_valid !== mon_e.valid || err !== mon_e.err) begin
                    bad++;
                    $display("FAIL event: got entry=%h cnt=%0d value=%h valid=%b err=%b, need entry=%h cnt=%0d value=%h valid=%b err=%b",
                             entry, digit_cnt, value, value_valid, err,
                             mon_e.entry, mon_e.cnt, mon_e.value, mon_e.valid, mon_e.err);
                end
            end else if (value_valid !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL stray_pulse: got valid=%b err=%b, need 0/0 at %0t", value_valid, err, $time);
            end
        end
    end

    task automatic press(input logic [4:0] code, input int hold, input int rel);
        @(negedge clk);
        key_code   = code;
        key_strobe = 1'b1;
        model_press(code);
        repeat (hold) @(negedge clk);
        key_strobe = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        key_code   = '0;
        key_strobe = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (entry !== 16'h0 || digit_cnt !== 3'd0 || value !== 16'h0 ||
            value_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got entry=%h cnt=%0d value=%h valid=%b err=%b busy=%b, need all 0",
                     entry, digit_cnt, value, value_valid, err, busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_entry_enter;
        press(5'd3, 5, 5);
        total++;
        if (entry !== 16'h0003) begin bad++; $display("FAIL first_digit: got %h need 0003", entry); end
        press(5'd10, 2, 5);
        total++;
        if (entry !== 16'h003A || digit_cnt !== 3'd2) begin
            bad++; $display("FAIL second_digit: got %h/%0d need 003A/2", entry, digit_cnt);
        end
        press(5'd18, 1, 5);
        total++;
        if (value !== 16'h003A || entry !== 16'h0 || digit_cnt !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL enter: got value=%h entry=%h cnt=%0d busy=%b need 003A/0000/0/0",
                            value, entry, digit_cnt, busy);
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 5; i++) press(5'(i), 1, 5);
        total++;
        if (entry !== 16'h1234 || digit_cnt !== 3'd4) begin
            bad++; $display("FAIL overflow: got %h/%0d need 1234/4", entry, digit_cnt);
        end
    endtask

    task automatic test_backspace;
        press(5'd16, 1, 5);
        press(5'd25, 1, 5);
        press(5'd1, 1, 5);
        press(5'd2, 1, 5);
        press(5'd17, 1, 5);
        total++;
        if (entry !== 16'h0001 || digit_cnt !== 3'd1) begin
            bad++; $display("FAIL backspace: got %h/%0d need 0001/1", entry, digit_cnt);
        end
        press(5'd17, 1, 5);
        press(5'd17, 1, 5);
        total++;
        if (entry !== 16'h0000 || digit_cnt !== 3'd0) begin
            bad++; $display("FAIL backspace_empty: got %h/%0d need 0000/0", entry, digit_cnt);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        key_code   = 5'd7;
        key_strobe = 1'b1;
        model_press(5'd7);
        repeat (2) @(negedge clk);
        key_strobe = 1'b0;
        @(negedge clk);
        key_strobe = 1'b1;
        repeat (2) @(negedge clk);
        key_strobe = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (entry !== 16'h0007 || digit_cnt !== 3'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL bounce: got entry=%h cnt=%0d busy=%b need 0007/1/0", entry, digit_cnt, busy);
        end
    endtask

    task automatic test_recall;
        press(5'd16, 1, 5);
        press(5'd11, 1, 5);
        press(5'd14, 1, 5);
        press(5'd14, 1, 5);
        press(5'd15, 1, 5);
        press(5'd18, 1, 5);
        press(5'd16, 1, 5);
        press(5'd19, 1, 5);
        total++;
        if (entry !== 16'hBEEF || digit_cnt !== 3'd4) begin
            bad++; $display("FAIL recall: got %h/%0d need BEEF/4", entry, digit_cnt);
        end
        press(5'd16, 1, 5);
        press(5'd18, 1, 5);
        total++;
        if (value !== 16'hBEEF) begin
            bad++; $display("FAIL enter_empty: got value=%h need BEEF", value);
        end
    endtask

    task automatic test_async_reset;
        press(5'd16, 1, 5);
        press(5'd1, 1, 5);
        @(negedge clk);
        key_code   = 5'd2;
        key_strobe = 1'b1;
        model_press(5'd2);
        @(posedge clk);
        #3;
        total++;
        if (entry !== 16'h0012 || busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got entry=%h busy=%b need 0012/1", entry, busy);
        end
        rst = 1'b0;
        #1;
        total++;
        if (entry !== 16'h0 || digit_cnt !== 3'd0 || value !== 16'h0 ||
            value_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset: got entry=%h cnt=%0d value=%h valid=%b err=%b busy=%b need all 0",
                            entry, digit_cnt, value, value_valid, err, busy);
        end
        m_entry = '0;
        m_cnt   = '0;
        m_value = '0;
        @(negedge clk);
        rst = 1'b1;
        model_press(5'd2);
        @(negedge clk);
        total++;
        if (entry !== 16'h0002 || digit_cnt !== 3'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL held_after_reset: got entry=%h cnt=%0d busy=%b need 0002/1/1", entry, digit_cnt, busy);
        end
        key_strobe = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || entry !== 16'h0002) begin
            bad++; $display("FAIL post_reset_idle: got busy=%b entry=%h need 0/0002", busy, entry);
        end
    endtask

    initial begin
        test_reset;
        test_entry_enter;
        test_overflow;
        test_backspace;
        test_glitch;
        test_recall;
        test_async_reset;
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending need 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
